// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared constants and helpers for the 7-segment scan driver.
//   - Segment patterns are ordered {g,f,e,d,c,b,a}.
//   - Everything that reaches the display pins is active-low: a 0 lights
//     the segment / enables the anode, a 1 turns it off.
//   - idx_width(): counter width for a value range of n, never below 1 bit.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode
// Combinational nibble -> active-low segment pattern.
// Ports:
//   value : 4-bit digit value
//   hex   : 1 = show A..F, 0 = decimal only (A..F blank)
//   seg   : segments {g,f,e,d,c,b,a}, active-low
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] value,
  input  logic       hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (value)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = hex ? SEG_A : SEG_BLANK;
      4'hB: seg = hex ? SEG_B : SEG_BLANK;
      4'hC: seg = hex ? SEG_C : SEG_BLANK;
      4'hD: seg = hex ? SEG_D : SEG_BLANK;
      4'hE: seg = hex ? SEG_E : SEG_BLANK;
      4'hF: seg = hex ? SEG_F : SEG_BLANK;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed driver for a DIGITS-wide common-anode 7-segment display.
// One digit is enabled per slot of SCAN_DIV clocks; the first GUARD clocks
// of every slot keep all anodes off to avoid ghosting between digits.
// Ports:
//   clk    : system clock
//   reset  : asynchronous, active-high
//   din    : packed digits, nibble i = digit i (digit 0 rightmost)
//   dp     : decimal-point request per digit
//   load   : capture din/dp into the shadow registers
//   hex    : 1 = hex decode, 0 = decimal decode
//   lz     : 1 = suppress leading zeros
//   seg7   : segments {g,f,e,d,c,b,a}, active-low, registered
//   dp_n   : decimal point, active-low, registered
//   an     : digit enables, active-low, registered, at most one low
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter int GUARD    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   din,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  input  logic                  hex,
  input  logic                  lz,
  output logic [6:0]            seg7,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     an
);

  localparam int IW  = idx_width(DIGITS);
  localparam int PW  = idx_width(SCAN_DIV);
  localparam int PW1 = PW + 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [PW:0]   GUARD_V    = PW1'(GUARD);

  logic [PW-1:0]       presc;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] din_sh;
  logic [DIGITS-1:0]   dp_sh;

  logic [DIGITS-1:0]   lead_zero;
  logic                zero_run;
  logic [3:0]          nib_sel;
  logic                dp_sel;
  logic                sup_sel;
  logic                in_guard;
  logic [6:0]          dec_seg;
  logic [DIGITS-1:0]   an_act;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PRESC_LAST) begin
      presc <= '0;
      idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Whole-word capture, so the scan never sees a half-updated value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      din_sh <= '0;
      dp_sh  <= '0;
    end else if (load) begin
      din_sh <= din;
      dp_sh  <= dp;
    end
  end

  // lead_zero[i]: nibbles i..DIGITS-1 are all zero. Digit 0 never qualifies.
  always_comb begin
    lead_zero = '0;
    zero_run  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run     = zero_run & (din_sh[4*i +: 4] == 4'd0);
      lead_zero[i] = zero_run;
    end
  end

  always_comb begin
    nib_sel = '0;
    dp_sel  = 1'b0;
    sup_sel = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib_sel = din_sh[4*i +: 4];
        dp_sel  = dp_sh[i];
        sup_sel = lead_zero[i];
      end
    end
  end

  seg7_hex_decode u_decode (
    .value (nib_sel),
    .hex   (hex),
    .seg   (dec_seg)
  );

  assign in_guard = ({1'b0, presc} < GUARD_V);
  assign an_act   = ~(DIGITS'(1) << idx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg7 <= SEG_BLANK;
      dp_n <= 1'b1;
      an   <= '1;
    end else if (in_guard) begin
      seg7 <= SEG_BLANK;
      dp_n <= 1'b1;
      an   <= '1;
    end else begin
      seg7 <= (lz && sup_sel) ? SEG_BLANK : dec_seg;
      dp_n <= ~dp_sel;
      an   <= an_act;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int GUARD    = 1;

  localparam logic [6:0] P_BLANK = 7'b1111111;
  localparam logic [6:0] P_0 = 7'b1000000;
  localparam logic [6:0] P_1 = 7'b1111001;
  localparam logic [6:0] P_2 = 7'b0100100;
  localparam logic [6:0] P_3 = 7'b0110000;
  localparam logic [6:0] P_4 = 7'b0011001;
  localparam logic [6:0] P_5 = 7'b0010010;
  localparam logic [6:0] P_9 = 7'b0010000;

  typedef struct packed {
    logic [6:0] seg;
    logic       dpn;
    logic [3:0] an;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] din;
  logic [3:0]  dp;
  logic        load;
  logic        hex;
  logic        lz;
  logic [6:0]  seg7;
  logic        dp_n;
  logic [3:0]  an;

  int errors = 0;
  int checks = 0;

  // reference model state
  int          m_p;
  int          m_i;
  logic [15:0] m_din;
  logic [3:0]  m_dp;
  exp_t        sb[$];

  seg7_scan_driver #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .GUARD(GUARD)) dut (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .dp    (dp),
    .load  (load),
    .hex   (hex),
    .lz    (lz),
    .seg7  (seg7),
    .dp_n  (dp_n),
    .an    (an)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_dec(input logic [3:0] n, input logic h);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return h ? 7'b0001000 : P_BLANK;
      4'hB: return h ? 7'b0000011 : P_BLANK;
      4'hC: return h ? 7'b1000110 : P_BLANK;
      4'hD: return h ? 7'b0100001 : P_BLANK;
      4'hE: return h ? 7'b0000110 : P_BLANK;
      default: return h ? 7'b0001110 : P_BLANK;
    endcase
  endfunction

  function automatic exp_t model_out();
    exp_t        e;
    logic [15:0] upper;
    logic [3:0]  n;
    if (m_p < GUARD) begin
      e.seg = P_BLANK;
      e.dpn = 1'b1;
      e.an  = 4'hF;
    end else begin
      upper = m_din >> (4 * m_i);
      n     = upper[3:0];
      e.an  = ~(4'b0001 << m_i);
      e.dpn = ~m_dp[m_i];
      e.seg = (lz && (m_i != 0) && (upper == 16'h0)) ? P_BLANK : ref_dec(n, hex);
    end
    return e;
  endfunction

  function automatic int an_digit(input logic [3:0] a);
    for (int i = 0; i < 4; i++)
      if (a == ~(4'b0001 << i)) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_p   = 0;
    m_i   = 0;
    m_din = 16'h0;
    m_dp  = 4'h0;
    sb.delete();
  endtask

  // One clock: push the expected result from the state held before the
  // edge, advance the model, then pop it next to the sampled DUT outputs.
  task automatic tick(output exp_t e, output exp_t o);
    sb.push_back(model_out());
    @(posedge clk);
    if (load) begin
      m_din = din;
      m_dp  = dp;
    end
    if (m_p == SCAN_DIV - 1) begin
      m_p = 0;
      m_i = (m_i + 1) % DIGITS;
    end else begin
      m_p++;
    end
    #1;
    o = {seg7, dp_n, an};
    e = sb.pop_front();
  endtask

  task automatic test_reset();
    exp_t e, o;
    bit   found;
    reset = 1'b1;
    #12;
    checks++;
    if ({seg7, dp_n, an} !== {P_BLANK, 1'b1, 4'hF}) begin
      errors++;
      $display("FAIL reset_state: got %b want %b", {seg7, dp_n, an}, {P_BLANK, 1'b1, 4'hF});
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    din = 16'h1234; load = 1'b1;
    tick(e, o);
    load = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick(e, o);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_model: got %b want %b", o, e);
      end
      if (o.an === 4'b1101) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_reach_an1101: got an=%b want 1101 within 40 cycles", an);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({seg7, dp_n, an} !== {P_BLANK, 1'b1, 4'hF}) begin
      errors++;
      $display("FAIL reset_async: got %b want %b", {seg7, dp_n, an}, {P_BLANK, 1'b1, 4'hF});
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      tick(e, o);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_restart_model: got %b want %b", o, e);
      end
      if (o.an !== 4'hF) begin
        found = 1'b1;
        checks++;
        if (o.an !== 4'b1110) begin
          errors++;
          $display("FAIL reset_first_digit: got an=%b want 1110", o.an);
        end
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_first_active: got no active slot want an=1110 within 10 cycles");
    end
  endtask

  task automatic test_decimal();
    exp_t       e, o;
    logic [6:0] want [4];
    int         d;
    want[0] = P_4; want[1] = P_3; want[2] = P_2; want[3] = P_1;
    hex = 1'b0; lz = 1'b0; dp = 4'h0;
    din = 16'h1234; load = 1'b1;
    tick(e, o);
    load = 1'b0;
    for (int k = 0; k < 2 * DIGITS * SCAN_DIV; k++) begin
      tick(e, o);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL dec_model: got %b want %b", o, e);
      end
      d = an_digit(o.an);
      if (d >= 0) begin
        checks++;
        if (o.seg !== want[d]) begin
          errors++;
          $display("FAIL dec_digit%0d: got %b want %b", d, o.seg, want[d]);
        end
      end
    end
  endtask

  task automatic test_hex();
    exp_t       e, o;
    logic [6:0] want [4];
    int         d, act;
    want[0] = 7'b0001110; want[1] = 7'b1000110; want[2] = 7'b0000011; want[3] = 7'b0001000;
    hex = 1'b1; lz = 1'b0; dp = 4'h0;
    din = 16'hABCF; load = 1'b1;
    tick(e, o);
    load = 1'b0;
    for (int k = 0; k < DIGITS * SCAN_DIV; k++) begin
      tick(e, o);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL hex_model: got %b want %b", o, e);
      end
      d = an_digit(o.an);
      if (d >= 0) begin
        checks++;
        if (o.seg !== want[d]) begin
          errors++;
          $display("FAIL hex_digit%0d: got %b want %b", d, o.seg, want[d]);
        end
      end
    end
    hex = 1'b0;
    act = 0;
    for (int k = 0; k < DIGITS * SCAN_DIV; k++) begin
      tick(e, o);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL hexoff_model: got %b want %b", o, e);
      end
      d = an_digit(o.an);
      if (d >= 0) begin
        act++;
        checks++;
        if (o.seg !== P_BLANK) begin
          errors++;
          $display("FAIL hexoff_blank%0d: got %b want %b", d, o.seg, P_BLANK);
        end
      end
    end
    checks++;
    if (act !== DIGITS * (SCAN_DIV - GUARD)) begin
      errors++;
      $display("FAIL hexoff_an_cycling: got %0d active cycles want %0d", act, DIGITS * (SCAN_DIV - GUARD));
    end
  endtask

  task automatic test_lz();
    exp_t        e, o;
    logic [15:0] vals [3];
    logic [6:0]  want [3][4];
    int          d;
    vals[0] = 16'h0050; vals[1] = 16'h0000; vals[2] = 16'h0A00;
    want[0][0] = P_0; want[0][1] = P_5;     want[0][2] = P_BLANK; want[0][3] = P_BLANK;
    want[1][0] = P_0; want[1][1] = P_BLANK; want[1][2] = P_BLANK; want[1][3] = P_BLANK;
    want[2][0] = P_0; want[2][1] = P_0;     want[2][2] = P_BLANK; want[2][3] = P_BLANK;
    hex = 1'b0; lz = 1'b1; dp = 4'h0;
    for (int v = 0; v < 3; v++) begin
      din = vals[v]; load = 1'b1;
      tick(e, o);
      load = 1'b0;
      for (int k = 0; k < DIGITS * SCAN_DIV; k++) begin
        tick(e, o);
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL lz_model_%h: got %b want %b", vals[v], o, e);
        end
        d = an_digit(o.an);
        if (d >= 0) begin
          checks++;
          if (o.seg !== want[v][d]) begin
            errors++;
            $display("FAIL lz_%h_digit%0d: got %b want %b", vals[v], d, o.seg, want[v][d]);
          end
        end
      end
    end
    lz = 1'b0;
  endtask

  task automatic test_dp();
    exp_t e, o;
    logic want_dpn;
    hex = 1'b0; lz = 1'b0;
    din = 16'h1234; dp = 4'b0100; load = 1'b1;
    tick(e, o);
    load = 1'b0;
    for (int k = 0; k < 2 * DIGITS * SCAN_DIV; k++) begin
      tick(e, o);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL dp_model: got %b want %b", o, e);
      end
      want_dpn = (o.an === 4'b1011) ? 1'b0 : 1'b1;
      checks++;
      if (o.dpn !== want_dpn) begin
        errors++;
        $display("FAIL dp_n: got %b want %b (an=%b)", o.dpn, want_dpn, o.an);
      end
    end
    dp = 4'h0;
  endtask

  task automatic test_back_to_back();
    exp_t e, o;
    bit   found;
    hex = 1'b0; lz = 1'b0; dp = 4'h0;
    din = 16'h5555; load = 1'b1;
    tick(e, o);
    load = 1'b0;
    din = 16'h9999;
    found = 1'b0;
    for (int k = 0; k < 3 * SCAN_DIV && !found; k++) begin
      if (m_p == SCAN_DIV - 1 && k > 0) begin
        found = 1'b1;
      end else begin
        tick(e, o);
        checks++;
        if (o.seg === P_9) begin
          errors++;
          $display("FAIL wrap_early: got %b before load want not %b", o.seg, P_9);
        end
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wrap_sync: got no wrap cycle want one within %0d cycles", 3 * SCAN_DIV);
    end
    load = 1'b1;
    tick(e, o);
    load = 1'b0;
    checks++;
    if (o !== e || o.seg !== P_5) begin
      errors++;
      $display("FAIL wrap_old: got %b want %b seg %b", o, e, P_5);
    end
    tick(e, o);
    checks++;
    if (o !== e || o.an !== 4'hF) begin
      errors++;
      $display("FAIL wrap_guard: got %b want %b an 1111", o, e);
    end
    tick(e, o);
    checks++;
    if (o !== e || o.seg !== P_9 || o.an === 4'hF) begin
      errors++;
      $display("FAIL wrap_new: got %b want %b seg %b", o, e, P_9);
    end
    for (int k = 0; k < DIGITS * SCAN_DIV; k++) begin
      tick(e, o);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL wrap_model: got %b want %b", o, e);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    din   = 16'h0;
    dp    = 4'h0;
    load  = 1'b0;
    hex   = 1'b0;
    lz    = 1'b0;
    model_reset();
    test_reset();
    test_decimal();
    test_hex();
    test_lz();
    test_dp();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Time-multiplexed driver for a DIGITS-wide common-anode 7-segment display.
- Latches a packed nibble word on LOAD and scans one digit per slot.
- Decodes each digit in decimal or hex mode, with optional leading-zero suppression, per-digit decimal points and an anti-ghosting guard.
- Sits between the CPU output port register and the board display pins.
- Supersedes per-digit combinational decoders.

Parameters:
DIGITS, 4, number of digits scanned (1..8)
SCAN_DIV, 50000, CLK cycles per digit slot (>= GUARD+1)
GUARD, 2, CLK cycles at the start of each slot with all anodes off (0 allowed)

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
DIN  in  4*DIGITS  packed value; nibble i = digit i, digit 0 rightmost
DP  in  DIGITS  decimal-point request, bit i = digit i
LOAD  in  1  capture DIN/DP into shadow registers on this CLK edge
HEX  in  1  1 = hex decode, 0 = decimal decode
LZ  in  1  1 = suppress leading zeros
SEG7  out  7  segments g..a, active-low
DP_N  out  1  decimal point, active-low
AN  out  DIGITS  digit enables, active-low, at most one low

Behaviour:
- Reset (async, immediate): shadow value and DP cleared; prescaler = 0; digit index = 0; SEG7 = 7'b1111111; DP_N = 1; AN = all ones.
- Shadow capture: LOAD=1 at an edge writes the DIN and DP shadows. Outputs never read DIN directly.
- Prescaler: counts 0..SCAN_DIV-1. At the terminal count it wraps to 0 and the digit index increments, wrapping DIGITS-1 -> 0.
- All outputs are registered. At edge k they reflect the prescaler, index and shadow values held before edge k, so latency is 1 cycle.
- A LOAD at edge k is first visible at edge k+1.
- Guard: while prescaler < GUARD, AN = all ones, SEG7 = 1111111 and DP_N = 1.
- Active slot: otherwise AN = ~(1 << index).
  - SEG7 = decode(nibble[index]), unless the digit is suppressed.
  - DP_N = ~DP_shadow[index]. DP is shown even on suppressed digits.
- Decimal decode (HEX=0): 0..9 map to 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000. A..F are blank (1111111).
- Hex decode (HEX=1): 0..9 as above, plus A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Leading-zero suppression (LZ=1): digit i (i>0) is suppressed (SEG7 = 1111111) when every nibble j with i <= j <= DIGITS-1 equals 0.
  - Digit 0 is never suppressed.
  - A nibble > 9 in decimal mode counts as non-zero.
- HEX and LZ are sampled every cycle, not shadowed. A change takes effect at the next edge.
- LOAD coinciding with a slot boundary: the new slot shows the old value for that cycle and the new value from the following edge. No partially updated nibble is ever driven.
- DIGITS=1: AN is constant 0 outside the guard, and the index stays 0.

Decomposition:
- Package seg7_pkg holds:
  - localparam segment constants SEG_BLANK and SEG_0..SEG_F;
  - the active-low convention note;
  - a function for the index width, clog2(DIGITS) with a minimum of 1.
- One sub-module, seg7_hex_decode: 4-bit value + HEX -> 7-bit pattern, purely combinational, instantiated once on the selected nibble.
- Top level holds the prescaler, digit index, shadow registers, LZ mask and output registers.

Test Plan:
(Bench parameters: DIGITS=4, SCAN_DIV=4, GUARD=1.)
1. Reset mid-scan while AN=1101 -> AN=1111, SEG7=1111111 and DP_N=1 without waiting for a CLK edge. After release, the first active slot is digit 0.
2. LOAD DIN=16'h1234, HEX=0, LZ=0 -> each slot is 1 cycle AN=1111 then 3 cycles active:
   - AN=1110, SEG7=0011001;
   - AN=1101, SEG7=0110000;
   - AN=1011, SEG7=0100100;
   - AN=0111, SEG7=1111001;
   - then wrap to digit 0.
3. DIN=16'hABCF:
   - HEX=1 -> digits 0..3 show 0001110, 1000110, 0000011, 0001000.
   - HEX=0 -> all four show 1111111 with AN still cycling.
4. LZ=1:
   - DIN=16'h0050 -> digits 3 and 2 show 1111111, digit 1 shows 0010010, digit 0 shows 1000000.
   - DIN=16'h0000 -> only digit 0 shows 1000000.
   - DIN=16'h0A00 with HEX=0 -> digit 2 is blank but not suppressed, and digit 3 is suppressed.
5. DP=4'b0100 -> DP_N=0 only while AN=1011 outside the guard; DP_N=1 in all other cycles.
6. LOAD of 16'h9999 on the cycle the prescaler wraps -> the new slot shows the old nibble for exactly 1 cycle, then 0010000. The 9999 value is never shown before the LOAD edge.
